// File: rtl/altsyncram_readback_model_if.sv
// ---------------------------------------------------------------------------
// altsyncram_readback_model_if
//   Bus bundle for the valid-bit readback RAM model.
//   Channel b is the write side, channel a is the read side.
//   master : drives the write/read requests and observes the responses.
//   slave  : the RAM model itself.
//   Signals:
//     wren_b, address_b, valid_b : write strobe, write address, bit to store
//     rden_a, address_a          : read request and read address
//     init_busy                  : clear sweep in progress, requests ignored
//     rdvalid_a                  : one-cycle read response strobe
//     valid_q_a/av_q_a/ai_q_a/assign_q_a : response flags
// ---------------------------------------------------------------------------
interface altsyncram_readback_model_if #(
  parameter int widthad = 4
);
  logic               wren_b;
  logic [widthad-1:0] address_b;
  logic               valid_b;
  logic               rden_a;
  logic [widthad-1:0] address_a;
  logic               init_busy;
  logic               rdvalid_a;
  logic               valid_q_a;
  logic               av_q_a;
  logic               ai_q_a;
  logic               assign_q_a;

  modport master (
    output wren_b, address_b, valid_b, rden_a, address_a,
    input  init_busy, rdvalid_a, valid_q_a, av_q_a, ai_q_a, assign_q_a
  );

  modport slave (
    input  wren_b, address_b, valid_b, rden_a, address_a,
    output init_busy, rdvalid_a, valid_q_a, av_q_a, ai_q_a, assign_q_a
  );
endinterface

// File: rtl/altsyncram_readback_model.sv
// ---------------------------------------------------------------------------
// altsyncram_readback_model
//   Tracks one valid bit per word. Channel b writes the bit, channel a reads
//   it back through a fully pipelined read-enable handshake with 1 or 2
//   cycles of latency (outreg_a). After every reset an init sweep clears all
//   numwords entries; requests arriving during the sweep are dropped.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high
//     bus   : altsyncram_readback_model_if.slave (requests in, responses out)
//   Parameters:
//     numwords : number of tracked words (<= 2**widthad)
//     widthad  : address width
//     outreg_a : 0 -> 1-cycle read latency, 1 -> 2-cycle read latency
// ---------------------------------------------------------------------------
module altsyncram_readback_model #(
  parameter int numwords = 16,
  parameter int widthad  = 4,
  parameter int outreg_a = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  altsyncram_readback_model_if.slave        bus
);

  localparam int                 LAT  = (outreg_a != 0) ? 2 : 1;
  localparam logic [widthad-1:0] LAST = widthad'(numwords - 1);
  localparam logic [widthad:0]   NW_W = (widthad + 1)'(numwords);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [widthad-1:0] cnt_q, cnt_d;
  logic               clr_we;

  logic [numwords-1:0] ram_q;

  logic ready;
  logic wr_en;
  logic rd_en;
  logic rd_bit;

  logic [LAT:1] vld_pipe_q;
  logic [LAT:1] bit_pipe_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // INIT clears one word per cycle; leaving INIT happens on the same edge
  // that clears the last word, so the sweep is exactly numwords cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_INIT: begin
        clr_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready = (state_q == S_READY);

  // -------------------------------------------------------- request decode
  assign wr_en = ready & bus.wren_b & ({1'b0, bus.address_b} < NW_W);
  assign rd_en = ready & bus.rden_a;

  // Combinational look-up of the pre-edge contents: a same-edge write is
  // not yet in ram_q, which gives old-data behaviour on collisions.
  // Out-of-range reads still respond, with the bit forced to 0.
  always_comb begin
    rd_bit = 1'b0;
    if ({1'b0, bus.address_a} < NW_W) begin
      rd_bit = ram_q[bus.address_a];
    end
  end

  // ---------------------------------------------------------------- storage
  // Contents are not reset directly; the sweep that follows reset clears
  // them before any read can be accepted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we) begin
        ram_q[cnt_q] <= 1'b0;
      end else if (wr_en) begin
        ram_q[bus.address_b] <= bus.valid_b;
      end
    end
  end

  // ------------------------------------------------------------ read pipe
  // Stage 1 is the synchronous RAM read; stage 2 (outreg_a=1) is the output
  // register. Reset flushes every stage so in-flight reads never respond.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_q <= '0;
      bit_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= rd_en;
      bit_pipe_q[1] <= rd_en & rd_bit;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        bit_pipe_q[i] <= bit_pipe_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------- outputs
  // The stored bit is already gated with the valid stage, so every flag is
  // 0 when no response is present.
  assign bus.init_busy  = ~ready;
  assign bus.rdvalid_a  = vld_pipe_q[LAT];
  assign bus.valid_q_a  = bit_pipe_q[LAT];
  assign bus.av_q_a     = bit_pipe_q[LAT];
  assign bus.ai_q_a     = vld_pipe_q[LAT] & ~bit_pipe_q[LAT];
  assign bus.assign_q_a = bus.av_q_a | bus.ai_q_a;

endmodule
